// File: rtl/bit_timing_gen_rx.sv
// bit_timing_gen_rx: fractional bit-timing generator with shadowed config,
// resync realignment and word position tracking.
module bit_timing_gen_rx #(
    parameter int CNT_W       = 6,
    parameter int DEN_W       = 4,
    parameter int WORD_BITS   = 8,
    parameter int RST_PERIOD  = 8,
    parameter int RST_NUM     = 1,
    parameter int RST_DEN     = 3,
    parameter int RST_SAMPLE  = 4,
    parameter int RESYNC_LOAD = 1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         resync,
    input  logic [CNT_W-1:0]             cfg_period,
    input  logic [DEN_W-1:0]             cfg_frac_num,
    input  logic [DEN_W-1:0]             cfg_frac_den,
    input  logic [CNT_W-1:0]             cfg_sample,
    input  logic                         cfg_load,
    output logic [CNT_W-1:0]             count_out,
    output logic                         long_bit,
    output logic                         sample_strobe,
    output logic                         bit_end,
    output logic [$clog2(WORD_BITS)-1:0] bit_idx,
    output logic                         word_end
);
    localparam int IDX_W = $clog2(WORD_BITS);

    logic [CNT_W-1:0] per_q, per_d, samp_q, samp_d, sh_per_q, sh_samp_q, cnt_q, cnt_d;
    logic [DEN_W-1:0] num_q, num_d, den_q, den_d, sh_num_q, sh_den_q;
    logic [DEN_W:0]   acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d, long_q, long_d;
    logic [CNT_W:0]   eff_per, len_m1;
    logic [DEN_W+1:0] t;
    logic             adv, wrap, apply;

    always_comb begin
        eff_per = (per_q < CNT_W'(2)) ? (CNT_W+1)'(2) : (CNT_W+1)'(per_q);
        len_m1  = eff_per + (CNT_W+1)'(long_q) - (CNT_W+1)'(1);
        adv     = enable & ~clear & ~resync;
        wrap    = adv & ({1'b0, cnt_q} == len_m1);
        apply   = pend_q & (clear | wrap);
        per_d   = apply ? sh_per_q : per_q;
        num_d   = apply ? sh_num_q : num_q;
        den_d   = apply ? sh_den_q : den_q;
        samp_d  = apply ? sh_samp_q : samp_q;
        pend_d  = cfg_load | (pend_q & ~apply);
        // acc can exceed a newly applied smaller den, so the sum gets a spare bit
        t       = (DEN_W+2)'(acc_q) + (DEN_W+2)'(num_d);
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        long_d  = long_q;
        idx_d   = idx_q;
        if (clear) begin
            cnt_d  = '0;
            acc_d  = '0;
            long_d = 1'b0;
            idx_d  = '0;
        end else if (resync) begin
            cnt_d = CNT_W'(RESYNC_LOAD);
        end else if (wrap) begin
            cnt_d  = '0;
            idx_d  = (idx_q == IDX_W'(WORD_BITS-1)) ? '0 : idx_q + 1'b1;
            long_d = (den_d != '0) && ((num_d >= den_d) || (t >= (DEN_W+2)'(den_d)));
            acc_d  = (den_d == '0) ? acc_q :
                     (num_d >= den_d) ? '0 :
                     (t >= (DEN_W+2)'(den_d)) ? (DEN_W+1)'(t - (DEN_W+2)'(den_d)) : (DEN_W+1)'(t);
        end else if (adv) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            per_q     <= CNT_W'(RST_PERIOD);
            num_q     <= DEN_W'(RST_NUM);
            den_q     <= DEN_W'(RST_DEN);
            samp_q    <= CNT_W'(RST_SAMPLE);
            sh_per_q  <= CNT_W'(RST_PERIOD);
            sh_num_q  <= DEN_W'(RST_NUM);
            sh_den_q  <= DEN_W'(RST_DEN);
            sh_samp_q <= CNT_W'(RST_SAMPLE);
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            long_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            per_q  <= per_d;
            num_q  <= num_d;
            den_q  <= den_d;
            samp_q <= samp_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            long_q <= long_d;
            idx_q  <= idx_d;
            if (cfg_load) begin
                sh_per_q  <= cfg_period;
                sh_num_q  <= cfg_frac_num;
                sh_den_q  <= cfg_frac_den;
                sh_samp_q <= cfg_sample;
            end
        end
    end

    assign count_out     = cnt_q;
    assign long_bit      = long_q;
    assign bit_idx       = idx_q;
    assign sample_strobe = n_rst & adv & (cnt_q == samp_q);
    assign bit_end       = n_rst & wrap;
    assign word_end      = bit_end & (idx_q == IDX_W'(WORD_BITS-1));
endmodule

// File: tb/tb_bit_timing_gen_rx.sv
// tb_bit_timing_gen_rx: scoreboard bench; a rule-level reference model queues
// expected outputs per cycle and a monitor compares them at the falling edge.
module tb_bit_timing_gen_rx;
    localparam int CW = 6, DW = 4, WB = 8, IW = 3;

    logic clk = 1'b0, n_rst = 1'b0, enable = 1'b0, clear = 1'b0, resync = 1'b0, cfg_load = 1'b0;
    logic [CW-1:0] cfg_period = '0, cfg_sample = '0;
    logic [DW-1:0] cfg_frac_num = '0, cfg_frac_den = '0;
    logic [CW-1:0] count_out;
    logic          long_bit, sample_strobe, bit_end, word_end;
    logic [IW-1:0] bit_idx;

    always #5 clk = ~clk;

    bit_timing_gen_rx dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .clear(clear), .resync(resync),
        .cfg_period(cfg_period), .cfg_frac_num(cfg_frac_num), .cfg_frac_den(cfg_frac_den),
        .cfg_sample(cfg_sample), .cfg_load(cfg_load), .count_out(count_out), .long_bit(long_bit),
        .sample_strobe(sample_strobe), .bit_end(bit_end), .bit_idx(bit_idx), .word_end(word_end)
    );

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          lng, smp, be;
        logic [IW-1:0] idx;
        logic          we;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   run_len = 0;
    int   lens[$];

    // reference model: active/shadow config, position within bit, accumulator, word index
    int m_per, m_num, m_den, m_samp, s_per, s_num, s_den, s_samp, m_pend, m_pos, m_acc, m_lng, m_idx;

    task automatic model_reset();
        m_per = 8; m_num = 1; m_den = 3; m_samp = 4;
        s_per = 8; s_num = 1; s_den = 3; s_samp = 4;
        m_pend = 0; m_pos = 0; m_acc = 0; m_lng = 0; m_idx = 0;
    endtask

    task automatic model_apply();
        if (m_pend != 0) begin
            m_per = s_per; m_num = s_num; m_den = s_den; m_samp = s_samp; m_pend = 0;
        end
    endtask

    task automatic model_next_long();
        if (m_den == 0) m_lng = 0;
        else if (m_num >= m_den) begin m_lng = 1; m_acc = 0; end
        else begin
            m_lng = (m_acc + m_num >= m_den) ? 1 : 0;
            m_acc = m_acc + m_num - ((m_lng != 0) ? m_den : 0);
        end
    endtask

    task automatic cyc(input bit en, input bit clr, input bit rs, input bit ld,
                       input int per = 0, input int num = 0, input int den = 0, input int samp = 0);
        obs_t e;
        int   len;
        bit   act;
        @(posedge clk); #1;
        n_rst = 1'b1; enable = en; clear = clr; resync = rs; cfg_load = ld;
        cfg_period = per[CW-1:0]; cfg_frac_num = num[DW-1:0]; cfg_frac_den = den[DW-1:0]; cfg_sample = samp[CW-1:0];
        len   = ((m_per < 2) ? 2 : m_per) + m_lng;
        act   = en && !clr && !rs;
        e.cnt = m_pos[CW-1:0];
        e.lng = m_lng[0];
        e.smp = act && (m_pos == m_samp);
        e.be  = act && (m_pos == len - 1);
        e.idx = m_idx[IW-1:0];
        e.we  = e.be && (m_idx == WB - 1);
        exp_q.push_back(e);
        if (clr) begin
            model_apply(); m_pos = 0; m_acc = 0; m_lng = 0; m_idx = 0;
        end else if (rs) m_pos = 1;
        else if (en) begin
            if (e.be) begin
                model_apply(); model_next_long(); m_pos = 0; m_idx = (m_idx + 1) % WB;
            end else m_pos++;
        end
        if (ld) begin
            s_per = per; s_num = num; s_den = den; s_samp = samp; m_pend = 1;
        end
    endtask

    task automatic rst_cyc(input bit en);
        @(posedge clk); #1;
        n_rst = 1'b0; enable = en; clear = 1'b0; resync = 1'b0; cfg_load = 1'b0;
        model_reset();
        exp_q.push_back('0);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // monitor: pops one expectation per cycle and measures bit lengths in enabled cycles
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.cnt = count_out; a.lng = long_bit; a.smp = sample_strobe;
                a.be = bit_end; a.idx = bit_idx; a.we = word_end;
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got cnt=%0d long=%b smp=%b be=%b idx=%0d we=%b, expected cnt=%0d long=%b smp=%b be=%b idx=%0d we=%b",
                             $time, a.cnt, a.lng, a.smp, a.be, a.idx, a.we, e.cnt, e.lng, e.smp, e.be, e.idx, e.we);
                end
                if (n_rst && enable && !clear && !resync) run_len++;
                if (bit_end) begin
                    lens.push_back(run_len);
                    run_len = 0;
                end
            end
        end
    end

    initial begin
        int want_len[7] = '{8, 8, 8, 9, 8, 8, 9};
        model_reset();
        // defaults with enable held high; reset cycles keep enable high
        rst_cyc(1); rst_cyc(1);
        lens.delete(); run_len = 0;
        for (int i = 0; i < 58; i++) cyc(1, 0, 0, 0);
        @(negedge clk); #1;
        check_val("bit_count", lens.size(), 7);
        for (int i = 0; i < 7; i++) check_val($sformatf("bit_len[%0d]", i), (i < lens.size()) ? lens[i] : -1, want_len[i]);
        // 16 bits for word_end / bit_idx wrap
        rst_cyc(0);
        for (int i = 0; i < 140; i++) cyc(1, 0, 0, 0);
        // cfg_load at count 3 of the first bit
        rst_cyc(0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1, 5, 0, 1, 2);
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0);
        // resync at count 6, then resync together with clear
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        // alternating enable
        for (int i = 0; i < 40; i++) cyc(i % 2 == 0, 0, 0, 0);
        // reset at count 5 of bit 3 with a pending config
        rst_cyc(0);
        for (int i = 0; i < 19; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1, 5, 0, 1, 2);
        cyc(1, 0, 0, 0);
        rst_cyc(1); rst_cyc(1);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
        // randomized traffic including clamped periods, den=0 and num>=den
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(299) == 0) rst_cyc($urandom_range(1) == 1);
            else cyc($urandom_range(3) != 0, $urandom_range(39) == 0, $urandom_range(39) == 0,
                     $urandom_range(19) == 0, $urandom_range(12), $urandom_range(5),
                     $urandom_range(5), $urandom_range(12));
        end
        cyc(0, 0, 0, 0);
        @(negedge clk); #1;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
